// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, counter width and FSM state encoding
package vga_timing_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_REQ_LEAD = 2;
    localparam int CNT_W        = 12;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage, W-bit shift register with async active-low reset; DEPTH=0 is a wire
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_thru
        logic unused_thru;
        assign unused_thru = clk ^ rst_n;
        assign q = d;
    end else begin : g_sr
        logic [W-1:0] sr [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, registered VGA sync/DE, and a pixel request leading DE by REQ_LEAD
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int REQ_LEAD = DEF_REQ_LEAD
)(
    input  logic             vga_pclk,
    input  logic             sys_rst_n,
    input  logic             en,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             line_start
);
    localparam logic [CNT_W-1:0] H_A    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_S0   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_S1   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_A    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_S0   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_S1   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // flag order: {hs, vs, de, frame, line}; sync levels already carry their polarity
    localparam logic [4:0] FLAG_IDLE = {~HS_POL, ~VS_POL, 3'b000};

    state_t state, state_nx;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nx, v_nx;
    logic h_last, v_last, req_nx, hs_nx, vs_nx;
    logic [4:0] flags_nx, flags_s1, flags_out;

    always_comb begin
        h_last = h_cnt == H_LAST;
        v_last = v_cnt == V_LAST;
        h_nx = '0;
        v_nx = '0;
        state_nx = state;
        if (state == IDLE) begin
            state_nx = en ? RUN : IDLE;
        end else begin
            h_nx = h_last ? '0 : h_cnt + 1'b1;
            v_nx = !h_last ? v_cnt : v_last ? '0 : v_cnt + 1'b1;
            state_nx = (h_last && v_last && !en) ? IDLE : RUN;
        end
    end

    always_ff @(posedge vga_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nx;
            h_cnt <= h_nx;
            v_cnt <= v_nx;
        end
    end

    always_comb begin
        req_nx = state == RUN && h_cnt < H_A && v_cnt < V_A;
        hs_nx = (h_cnt >= H_S0 && h_cnt < H_S1) ? HS_POL : ~HS_POL;
        vs_nx = (v_cnt >= V_S0 && v_cnt < V_S1) ? VS_POL : ~VS_POL;
        flags_nx = state == RUN ? {hs_nx, vs_nx, req_nx, req_nx && h_cnt == '0 && v_cnt == '0, req_nx && h_cnt == '0} : FLAG_IDLE;
    end

    always_ff @(posedge vga_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_req  <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            flags_s1 <= FLAG_IDLE;
        end else begin
            pix_req  <= req_nx;
            pix_x    <= req_nx ? h_cnt : '0;
            pix_y    <= req_nx ? v_cnt : '0;
            flags_s1 <= flags_nx;
        end
    end

    sync_delay_line #(.DEPTH(REQ_LEAD), .W(5), .RST_VAL(FLAG_IDLE)) u_delay (
        .clk   (vga_pclk),
        .rst_n (sys_rst_n),
        .d     (flags_s1),
        .q     (flags_out)
    );

    assign {vga_hs, vga_vs, vga_de, frame_start, line_start} = flags_out;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing table/measurement checks plus a scoreboarded small-raster instance
module tb_vga_timing_gen;
    typedef struct packed {
        logic hs, vs, de, req, fs, ls;
        logic [11:0] x, y;
    } out_t;

    typedef struct {
        int k;
        logic hs, vs, de, req, fs, ls;
        logic [11:0] x, y;
    } vec_t;

    localparam out_t IDLE_OUT = '{hs: 1'b1, vs: 1'b1, default: '0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0;
    logic hs_a, vs_a, de_a, req_a, fs_a, ls_a;
    logic hs_b, vs_b, de_b, req_b, fs_b, ls_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .vga_pclk(clk), .sys_rst_n(rst_n), .en(en_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .pix_req(req_a),
        .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a), .line_start(ls_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .REQ_LEAD(0)
    ) u_b (
        .vga_pclk(clk), .sys_rst_n(rst_n), .en(en_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .pix_req(req_b),
        .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b), .line_start(ls_b)
    );

    out_t got_a, got_b;
    assign got_a = {hs_a, vs_a, de_a, req_a, fs_a, ls_a, x_a, y_a};
    assign got_b = {hs_b, vs_b, de_b, req_b, fs_b, ls_b, x_b, y_b};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // 7x5 raster: sync at h=5, vsync on line 3, lead 0
    function automatic out_t b_exp(input bit run, input int t);
        out_t r;
        int h, v;
        h = t % 7;
        v = t / 7;
        r = IDLE_OUT;
        if (run) begin
            r.req = h < 4 && v < 2;
            r.de = r.req;
            r.hs = h != 5;
            r.vs = v != 3;
            r.fs = r.req && t == 0;
            r.ls = r.req && h == 0;
            r.x = r.req ? 12'(h) : 12'd0;
            r.y = r.req ? 12'(v) : 12'd0;
        end
        return r;
    endfunction

    out_t sb[$];
    out_t sb_e;
    bit m_run;
    int m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_t <= 0;
            sb.delete();
        end else begin
            sb.push_back(b_exp(m_run, m_t));
            if (!m_run) begin
                m_run <= en_b;
                m_t <= 0;
            end else if (m_t == 34) begin
                m_t <= 0;
                m_run <= en_b;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            sb_e = sb.pop_front();
            chk("sb_b", 32'(got_b), 32'(sb_e));
        end
    end

    initial begin
        vec_t tv[14];
        int ti = 0, nf = 0;
        int prev_fall = 0, fall_k = 0, de_rise = 0, de_fall = 0, req_rise = 0, nline = 0;
        int bad_per = 0, bad_low = 0, bad_dew = 0, bad_gap = 0, bad_lead = 0, bad_x = 0, bad_y = 0;
        int n_fs = 0, n_ls = 0, n_der = 0, bad_idle = 0, vs_low = 0, late_req = 0, lat = 0;
        logic p_hs = 1'b1, p_de = 1'b0, p_req = 1'b0;
        logic [11:0] p_x = '0;

        tv[0]  = '{1,   1, 1, 0, 0, 0, 0, 0,   0};
        tv[1]  = '{2,   1, 1, 0, 1, 0, 0, 0,   0};
        tv[2]  = '{3,   1, 1, 0, 1, 0, 0, 1,   0};
        tv[3]  = '{4,   1, 1, 1, 1, 1, 1, 2,   0};
        tv[4]  = '{5,   1, 1, 1, 1, 0, 0, 3,   0};
        tv[5]  = '{641, 1, 1, 1, 1, 0, 0, 639, 0};
        tv[6]  = '{642, 1, 1, 1, 0, 0, 0, 0,   0};
        tv[7]  = '{644, 1, 1, 0, 0, 0, 0, 0,   0};
        tv[8]  = '{659, 1, 1, 0, 0, 0, 0, 0,   0};
        tv[9]  = '{660, 0, 1, 0, 0, 0, 0, 0,   0};
        tv[10] = '{755, 0, 1, 0, 0, 0, 0, 0,   0};
        tv[11] = '{756, 1, 1, 0, 0, 0, 0, 0,   0};
        tv[12] = '{802, 1, 1, 0, 1, 0, 0, 0,   1};
        tv[13] = '{804, 1, 1, 1, 1, 0, 1, 2,   1};

        #7;
        chk("reset_a", 32'(got_a), 32'(IDLE_OUT));
        chk("reset_b", 32'(got_b), 32'(IDLE_OUT));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (got_a !== IDLE_OUT) bad_idle++;
        end
        chk("idle_a_pre", 32'(bad_idle), 0);

        en_a = 1'b1;
        en_b = 1'b1;
        for (int k = 1; k <= 3300; k++) begin
            @(negedge clk);
            if (p_hs && !hs_a) begin
                if (prev_fall != 0 && k - prev_fall != 800) bad_per++;
                if (de_fall == 0 || k - de_fall != 16) bad_gap++;
                prev_fall = k;
                fall_k = k;
            end
            if (!p_hs && hs_a && k - fall_k != 96) bad_low++;
            if (!p_req && req_a) begin
                req_rise = k;
                if (x_a != 12'd0) bad_x++;
                if (y_a != 12'(nline)) bad_y++;
                nline++;
            end else if (p_req && req_a && x_a != p_x + 12'd1) begin
                bad_x++;
            end
            if (!p_de && de_a) begin
                n_der++;
                de_rise = k;
                if (k - req_rise != 2) bad_lead++;
            end
            if (p_de && !de_a) begin
                de_fall = k;
                if (k - de_rise != 640) bad_dew++;
            end
            if (fs_a) n_fs++;
            if (ls_a) n_ls++;
            if (ti < 14 && tv[ti].k == k) begin
                chk($sformatf("vec_a_k%0d", k), 32'(got_a),
                    32'(out_t'{tv[ti].hs, tv[ti].vs, tv[ti].de, tv[ti].req, tv[ti].fs, tv[ti].ls, tv[ti].x, tv[ti].y}));
                ti++;
            end
            p_hs = hs_a;
            p_de = de_a;
            p_req = req_a;
            p_x = x_a;
        end
        chk("hs_period_bad", 32'(bad_per), 0);
        chk("hs_low_bad", 32'(bad_low), 0);
        chk("de_width_bad", 32'(bad_dew), 0);
        chk("hs_after_de_bad", 32'(bad_gap), 0);
        chk("req_lead_bad", 32'(bad_lead), 0);
        chk("pix_x_bad", 32'(bad_x), 0);
        chk("pix_y_bad", 32'(bad_y), 0);
        chk("last_hs_fall", 32'(prev_fall), 3060);
        chk("req_lines", 32'(nline), 5);
        chk("de_lines", 32'(n_der), 5);
        chk("line_starts", 32'(n_ls), 5);
        chk("frame_starts", 32'(n_fs), 1);

        while (nf < 100 && !fs_b) begin
            @(negedge clk);
            nf++;
        end
        chk("b_fs_found", 32'(fs_b), 1);
        repeat (10) @(negedge clk);
        en_b = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (!vs_b) vs_low++;
            if (i >= 30 && (req_b || fs_b || de_b)) late_req++;
        end
        chk("b_drop_vs_low", 32'(vs_low), 7);
        chk("b_drop_idle", 32'(late_req), 0);

        en_b = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (!fs_b && lat < 20);
        chk("b_restart_latency", 32'(lat), 2);

        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a", 32'(got_a), 32'(IDLE_OUT));
        chk("midrst_b", 32'(got_b), 32'(IDLE_OUT));
        en_a = 1'b0;
        en_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad_idle = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (got_a !== IDLE_OUT) bad_idle++;
        end
        chk("idle_a_post", 32'(bad_idle), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
